// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Brief   : Program-counter sequencer (IDLE/RUN/HALT) with PC-relative or
//           table-lookup branches. Lookup table built only when the macro
//           INSTR_FETCH_BRANCH_LUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         halt_req,
  input  logic                         do_branch,
  input  logic                         branch_abs,
  input  logic                         lut_sel,
  input  logic [7:0]                   target,
  input  logic                         lut_we,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
  input  logic [PC_W-1:0]              lut_wdata,
  output logic [PC_W-1:0]              prog_ctr,
  output logic                         fetch_valid,
  output logic                         done
);

  localparam int              C_LUT_IDX_W = $clog2(LUT_DEPTH);
  localparam logic [PC_W-1:0] C_PC_ZERO   = '0;
  localparam logic [PC_W-1:0] C_PC_ONE    = PC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic            r_done;
  logic            w_next_done;
  logic [PC_W-1:0] w_offset;
  logic [PC_W-1:0] w_rel_pc;
  logic [PC_W-1:0] w_branch_pc;
  logic            w_take;

  // Sign-extend the 8-bit offset; the sum wraps naturally at PC_W bits.
  assign w_offset = PC_W'($signed(target));
  assign w_rel_pc = r_pc + w_offset;
  assign w_take   = do_branch | branch_abs;

`ifdef INSTR_FETCH_BRANCH_LUT_EN
  logic [PC_W-1:0]        r_lut [LUT_DEPTH];
  logic [C_LUT_IDX_W-1:0] w_lut_idx;

  assign w_lut_idx = target[C_LUT_IDX_W-1:0];

  // Reads are combinational from the registered array, so a same-cycle
  // write is only visible from the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_lut[i] <= C_PC_ZERO;
      end
    end else if (lut_we) begin
      r_lut[lut_waddr] <= lut_wdata;
    end
  end

  assign w_branch_pc = lut_sel ? r_lut[w_lut_idx] : w_rel_pc;
`else
  logic w_unused_lut;

  assign w_unused_lut = ^{lut_sel, lut_we, lut_waddr, lut_wdata};
  assign w_branch_pc  = w_rel_pc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= C_PC_ZERO;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_done  <= w_next_done;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_done  = r_done;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_next_state = S_RUN;
          w_next_pc    = C_PC_ZERO;
          w_next_done  = 1'b0;
        end
      end
      S_RUN: begin
        // Stall freezes everything, including a pending halt or branch.
        if (!stall) begin
          if (halt_req) begin
            w_next_state = S_HALT;
            w_next_done  = 1'b1;
          end else if (w_take) begin
            w_next_pc = w_branch_pc;
          end else begin
            w_next_pc = r_pc + C_PC_ONE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_pc    = C_PC_ZERO;
        w_next_done  = 1'b0;
      end
    endcase
  end

  assign prog_ctr    = r_pc;
  assign done        = r_done;
  assign fetch_valid = (r_state == S_RUN) & ~stall;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Directed, table-driven self-checking bench for instr_fetch.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int PC_W      = 10;
  localparam int LUT_DEPTH = 16;
  localparam int IDX_W     = $clog2(LUT_DEPTH);

  logic             clk;
  logic             reset;
  logic             start;
  logic             stall;
  logic             halt_req;
  logic             do_branch;
  logic             branch_abs;
  logic             lut_sel;
  logic [7:0]       target;
  logic             lut_we;
  logic [IDX_W-1:0] lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  prog_ctr;
  logic             fetch_valid;
  logic             done;

  instr_fetch #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .halt_req    (halt_req),
    .do_branch   (do_branch),
    .branch_abs  (branch_abs),
    .lut_sel     (lut_sel),
    .target      (target),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .prog_ctr    (prog_ctr),
    .fetch_valid (fetch_valid),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            start;
    logic            stall;
    logic            halt;
    logic            br;
    logic            abs_br;
    logic            lsel;
    logic [7:0]      tgt;
    logic [PC_W-1:0] exp_pc;
    logic            exp_valid;
    logic            exp_done;
  } vec_t;

  vec_t vecs [40];
  int   n_vec;
  int   n_checks;
  int   n_errors;

  task automatic add(input logic s, input logic st, input logic h, input logic b,
                     input logic ab, input logic ls, input logic [7:0] t,
                     input logic [PC_W-1:0] pc, input logic v, input logic d);
    vecs[n_vec].start     = s;
    vecs[n_vec].stall     = st;
    vecs[n_vec].halt      = h;
    vecs[n_vec].br        = b;
    vecs[n_vec].abs_br    = ab;
    vecs[n_vec].lsel      = ls;
    vecs[n_vec].tgt       = t;
    vecs[n_vec].exp_pc    = pc;
    vecs[n_vec].exp_valid = v;
    vecs[n_vec].exp_done  = d;
    n_vec++;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input int v, input int d);
    chk({tag, " prog_ctr"}, int'(prog_ctr), pc);
    chk({tag, " fetch_valid"}, int'(fetch_valid), v);
    chk({tag, " done"}, int'(done), d);
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; halt_req = 0; do_branch = 0; branch_abs = 0;
    lut_sel = 0; target = 8'h00; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [PC_W-1:0] lut_br_pc;

  initial begin
    n_vec = 0; n_checks = 0; n_errors = 0;
    idle_inputs();
`ifdef INSTR_FETCH_BRANCH_LUT_EN
    lut_br_pc = 10'd0;   // lut[3] is cleared by reset
`else
    lut_br_pc = 10'd3;   // lut_sel ignored: relative branch from 0
`endif

    //   start st halt br abs lsel tgt    exp_pc      valid done
    add(1, 0, 0, 0, 0, 0, 8'h00, 10'd0,    1, 0);
    add(0, 0, 0, 0, 0, 0, 8'h00, 10'd1,    1, 0);
    add(0, 0, 0, 0, 0, 0, 8'h00, 10'd2,    1, 0);
    add(0, 0, 0, 0, 0, 0, 8'h00, 10'd3,    1, 0);
    add(0, 0, 0, 0, 0, 0, 8'h00, 10'd4,    1, 0);
    for (int i = 5; i <= 10; i++) add(0, 0, 0, 0, 0, 0, 8'h00, PC_W'(i), 1, 0);
    add(0, 0, 0, 1, 0, 0, 8'hFD, 10'd7,    1, 0);
    add(0, 0, 0, 1, 0, 0, 8'h05, 10'd12,   1, 0);
    add(0, 0, 0, 0, 1, 0, 8'h80, 10'd908,  1, 0);
    add(0, 1, 0, 1, 0, 0, 8'h05, 10'd908,  0, 0);
    add(0, 1, 1, 0, 0, 0, 8'h00, 10'd908,  0, 0);
    add(1, 0, 0, 0, 0, 0, 8'h00, 10'd909,  1, 0);
    add(0, 0, 0, 0, 0, 1, 8'h03, 10'd910,  1, 0);
    add(0, 0, 1, 1, 0, 0, 8'h05, 10'd910,  0, 1);
    add(0, 0, 0, 0, 0, 0, 8'h00, 10'd910,  0, 1);
    add(0, 0, 0, 1, 0, 0, 8'h05, 10'd910,  0, 1);
    add(1, 0, 0, 0, 0, 0, 8'h00, 10'd0,    1, 0);
    add(0, 0, 0, 1, 0, 0, 8'hFF, 10'd1023, 1, 0);
    add(0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    1, 0);
    add(0, 0, 0, 1, 0, 1, 8'h03, lut_br_pc, 1, 0);
    add(0, 0, 0, 0, 0, 0, 8'h00, lut_br_pc + 10'd1, 1, 0);

    reset = 1'b1;
    #2;
    chk_all("reset", 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_all("post-reset idle", 0, 0, 0);

    for (int i = 0; i < n_vec; i++) begin
      start      = vecs[i].start;
      stall      = vecs[i].stall;
      halt_req   = vecs[i].halt;
      do_branch  = vecs[i].br;
      branch_abs = vecs[i].abs_br;
      lut_sel    = vecs[i].lsel;
      target     = vecs[i].tgt;
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].exp_pc),
              int'(vecs[i].exp_valid), int'(vecs[i].exp_done));
    end
    idle_inputs();

    // Asynchronous reset between edges while running.
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_all("async reset mid-run", 0, 0, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("idle after reset %0d", i), 0, 0, 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart", 0, 1, 0);
    tick();
    chk_all("restart+1", 1, 1, 0);

`ifdef INSTR_FETCH_BRANCH_LUT_EN
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 10'd500;
    tick();
    chk_all("lut write", 2, 1, 0);
    lut_wdata = 10'd600;
    branch_abs = 1'b1; lut_sel = 1'b1; target = 8'h03;
    tick();
    chk_all("lut read old on write", 500, 1, 0);
    lut_we = 1'b0;
    tick();
    chk_all("lut read new", 600, 1, 0);
    idle_inputs();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
